// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V pipeline types: ALU ops, result-source encodings, decode control bundle
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_t;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    alu_op_t    alucrtl;
    logic [1:0] resultsrc;
    logic       memwrite;
    logic [1:0] alusrc;
    logic       regwrite;
    logic       jump;
    logic       branch;
    logic [2:0] f3;
  } ctrl_t;

endpackage

// File: rtl/load_use_det.sv
// rtl/load_use_det.sv - combinational load-use hazard detector between EX and decode
module load_use_det
  import riscv_pkg::*;
(
  input  logic       ex_valid,
  input  logic [1:0] ex_resultsrc,
  input  logic [4:0] ex_rd_addr,
  input  logic       id_valid,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       flush,
  output logic       lu_stall
);

  logic src_match;

  assign src_match = (id_rs1_addr == ex_rd_addr) || (id_rs2_addr == ex_rd_addr);

  // A flush already kills the decode instruction, so no stall is needed.
  assign lu_stall = ex_valid && (ex_resultsrc == RES_MEM) && (ex_rd_addr != 5'd0)
                    && id_valid && src_match && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with flush, stall and load-use bubble insertion
// Optional bubble counter enabled by IDEX_PERF_EN.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_stall,
  input  logic        i_flush,
  input  alu_op_t     i_alucrtl,
  input  logic [1:0]  i_resultsrc,
  input  logic        i_memwrite,
  input  logic [1:0]  i_alusrc,
  input  logic        i_regwrite,
  input  logic        i_jump,
  input  logic        i_branch,
  input  logic [2:0]  i_f3,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc4,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic [31:0] i_imm_ext,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  input  logic [4:0]  i_rd_addr,
  output logic        o_valid,
  output alu_op_t     o_alucrtl,
  output logic [1:0]  o_resultsrc,
  output logic        o_memwrite,
  output logic [1:0]  o_alusrc,
  output logic        o_regwrite,
  output logic        o_jump,
  output logic        o_branch,
  output logic [2:0]  o_f3,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  output logic [31:0] o_imm_ext,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [4:0]  o_rd_addr,
  output logic        o_lu_stall,
  output logic [31:0] o_bubble_cnt
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  logic  bubble;

  load_use_det u_load_use_det (
    .ex_valid     (o_valid),
    .ex_resultsrc (ctrl_q.resultsrc),
    .ex_rd_addr   (o_rd_addr),
    .id_valid     (i_valid),
    .id_rs1_addr  (i_rs1_addr),
    .id_rs2_addr  (i_rs2_addr),
    .flush        (i_flush),
    .lu_stall     (o_lu_stall)
  );

  // An invalid decode slot must not carry side effects into EX.
  always_comb begin
    ctrl_d = '{alucrtl:   i_alucrtl,
               resultsrc: i_resultsrc,
               memwrite:  i_memwrite,
               alusrc:    i_alusrc,
               regwrite:  i_regwrite,
               jump:      i_jump,
               branch:    i_branch,
               f3:        i_f3};
    if (!i_valid) begin
      ctrl_d.memwrite = 1'b0;
      ctrl_d.regwrite = 1'b0;
      ctrl_d.jump     = 1'b0;
      ctrl_d.branch   = 1'b0;
    end
  end

  assign bubble = i_flush || (!i_stall && o_lu_stall);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n || bubble) begin
      o_valid    <= 1'b0;
      ctrl_q     <= '0;
      o_pc       <= '0;
      o_pc4      <= '0;
      o_rs1_data <= '0;
      o_rs2_data <= '0;
      o_imm_ext  <= '0;
      o_rs1_addr <= '0;
      o_rs2_addr <= '0;
      o_rd_addr  <= '0;
    end else if (!i_stall) begin
      o_valid    <= i_valid;
      ctrl_q     <= ctrl_d;
      o_pc       <= i_pc;
      o_pc4      <= i_pc4;
      o_rs1_data <= i_rs1_data;
      o_rs2_data <= i_rs2_data;
      o_imm_ext  <= i_imm_ext;
      o_rs1_addr <= i_rs1_addr;
      o_rs2_addr <= i_rs2_addr;
      o_rd_addr  <= i_rd_addr;
    end
  end

  assign o_alucrtl   = ctrl_q.alucrtl;
  assign o_resultsrc = ctrl_q.resultsrc;
  assign o_memwrite  = ctrl_q.memwrite;
  assign o_alusrc    = ctrl_q.alusrc;
  assign o_regwrite  = ctrl_q.regwrite;
  assign o_jump      = ctrl_q.jump;
  assign o_branch    = ctrl_q.branch;
  assign o_f3        = ctrl_q.f3;

`ifdef IDEX_PERF_EN
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bubble_cnt_q <= '0;
    end else if (bubble) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign o_bubble_cnt = bubble_cnt_q;
`else
  assign o_bubble_cnt = '0;
`endif

endmodule
